dc_mcl_trm_sweep_manager: RTL and testbench

//  Generalised per-axis scaling-dimension sequencer for the main control logic.
//  - Produces curr_dim, which sweeps between min_dim and max_dim.
//  - Step size, dwell (frames per step) and mode (triangle / saw-up / saw-down / hold) are programmable.
//  - Every value change is handshaken with the config path (cfg_req/conf_ready).
//  - Advances only on frame events (user_int_valid). One instance per axis.

---
 rtl/dc_mcl_trm_sweep_manager.sv | 225 ++++++++++++++++++++++
 tb/tb_dc_mcl_trm_sweep_manager.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_mcl_trm_sweep_manager.sv
// dc_mcl_trm_sweep_manager
// Per-axis scaling-dimension sequencer. Sweeps curr_dim between min_dim and
// max_dim on frame events (triangle / saw-up / saw-down / hold). Every new
// value is offered to the config path with cfg_req and held until conf_ready.
module dc_mcl_trm_sweep_manager #(
  parameter int SCR_SIZE_WIDTH = 12,
  parameter int STEP_WIDTH     = 8,
  parameter int DWELL_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      sweep_en,
  input  logic [1:0]                mode,
  input  logic [STEP_WIDTH-1:0]     step,
  input  logic [DWELL_WIDTH-1:0]    dwell,
  input  logic                      user_int_valid,
  input  logic                      conf_ready,
  input  logic [SCR_SIZE_WIDTH-1:0] max_dim,
  input  logic [SCR_SIZE_WIDTH-1:0] min_dim,
  output logic [SCR_SIZE_WIDTH-1:0] curr_dim,
  output logic                      cfg_req,
  output logic                      dir,
  output logic                      cycle_done
);

  // One extra bit so up/down arithmetic never wraps before clamping.
  localparam int EXT_WIDTH = SCR_SIZE_WIDTH + 1;

  localparam logic [1:0] MODE_TRIANGLE = 2'b00;
  localparam logic [1:0] MODE_SAW_UP   = 2'b01;
  localparam logic [1:0] MODE_SAW_DOWN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UPD  = 2'd1,
    ST_WAIT = 2'd2
  } SweepState;

  SweepState                 r_state;
  SweepState                 w_nextState;
  logic [SCR_SIZE_WIDTH-1:0] r_currDim;
  logic [SCR_SIZE_WIDTH-1:0] w_currDimNext;
  logic                      r_dir;
  logic                      w_dirNext;
  logic [DWELL_WIDTH-1:0]    r_dwellCnt;
  logic [DWELL_WIDTH-1:0]    w_dwellCntNext;
  logic                      r_cfgReq;
  logic                      r_cycleDone;
  logic                      w_cycleDoneNext;

  logic                      w_frame;
  logic [SCR_SIZE_WIDTH-1:0] w_startDim;
  logic                      w_startDir;
  logic [EXT_WIDTH-1:0]      w_stepExt;
  logic [EXT_WIDTH-1:0]      w_currExt;
  logic [EXT_WIDTH-1:0]      w_minExt;
  logic [EXT_WIDTH-1:0]      w_maxExt;
  logic [EXT_WIDTH-1:0]      w_upSum;
  logic [EXT_WIDTH-1:0]      w_downDiff;
  logic                      w_downNeg;
  logic                      w_misconfig;
  logic                      w_atMax;
  logic                      w_atMin;
  logic [SCR_SIZE_WIDTH-1:0] w_upVal;
  logic [SCR_SIZE_WIDTH-1:0] w_downVal;
  logic [SCR_SIZE_WIDTH-1:0] w_stepVal;
  logic                      w_stepDir;
  logic                      w_stepDone;

  // A frame only counts while the config path is not acknowledging.
  assign w_frame     = user_int_valid & ~conf_ready;
  assign w_startDim  = (mode == MODE_SAW_DOWN) ? max_dim : min_dim;
  assign w_startDir  = (mode != MODE_SAW_DOWN);
  assign w_stepExt   = (step == '0) ? EXT_WIDTH'(1) : EXT_WIDTH'(step);
  assign w_currExt   = {1'b0, r_currDim};
  assign w_minExt    = {1'b0, min_dim};
  assign w_maxExt    = {1'b0, max_dim};
  assign w_upSum     = w_currExt + w_stepExt;
  assign w_downDiff  = w_currExt - w_stepExt;
  assign w_downNeg   = (w_currExt < w_stepExt);
  assign w_misconfig = (min_dim > max_dim);
  assign w_atMax     = (r_currDim >= max_dim);
  assign w_atMin     = (r_currDim <= min_dim);

  // Clamped up/down candidates; both sides clamp so bounds moved mid-sweep are honoured.
  always_comb begin
    w_upVal = w_upSum[SCR_SIZE_WIDTH-1:0];
    if (w_upSum > w_maxExt) begin
      w_upVal = max_dim;
    end else if (w_upSum < w_minExt) begin
      w_upVal = min_dim;
    end
    w_downVal = w_downDiff[SCR_SIZE_WIDTH-1:0];
    if (w_downNeg || (w_downDiff < w_minExt)) begin
      w_downVal = min_dim;
    end else if (w_downDiff > w_maxExt) begin
      w_downVal = max_dim;
    end
  end

  // Value, direction and period-end flag that one STEP would produce for the current mode.
  always_comb begin
    w_stepVal  = r_currDim;
    w_stepDir  = r_dir;
    w_stepDone = 1'b0;
    if (w_misconfig) begin
      w_stepVal = min_dim;
    end else begin
      case (mode)
        MODE_TRIANGLE: begin
          if (r_dir) begin
            if (w_atMax) begin
              w_stepDir = 1'b0;
              w_stepVal = w_downVal;
            end else begin
              w_stepVal = w_upVal;
            end
          end else begin
            if (w_atMin) begin
              w_stepDir  = 1'b1;
              w_stepVal  = w_upVal;
              w_stepDone = 1'b1;
            end else begin
              w_stepVal = w_downVal;
            end
          end
        end
        MODE_SAW_UP: begin
          w_stepDir = 1'b1;
          if (w_atMax) begin
            w_stepVal  = min_dim;
            w_stepDone = 1'b1;
          end else begin
            w_stepVal = w_upVal;
          end
        end
        MODE_SAW_DOWN: begin
          w_stepDir = 1'b0;
          if (w_atMin) begin
            w_stepVal  = max_dim;
            w_stepDone = 1'b1;
          end else begin
            w_stepVal = w_downVal;
          end
        end
        default: begin
          w_stepVal = r_currDim;
        end
      endcase
    end
  end

  // Next-state logic: sweep_en low forces IDLE ahead of everything else.
  always_comb begin
    w_nextState     = r_state;
    w_currDimNext   = r_currDim;
    w_dirNext       = r_dir;
    w_dwellCntNext  = r_dwellCnt;
    w_cycleDoneNext = 1'b0;
    if (!sweep_en) begin
      w_nextState    = ST_IDLE;
      w_currDimNext  = w_startDim;
      w_dirNext      = w_startDir;
      w_dwellCntNext = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_currDimNext  = w_startDim;
          w_dirNext      = w_startDir;
          w_dwellCntNext = '0;
          if (user_int_valid) begin
            w_nextState = ST_UPD;
          end
        end
        ST_UPD: begin
          if (conf_ready) begin
            w_nextState = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_frame) begin
            if (r_dwellCnt == dwell) begin
              w_dwellCntNext  = '0;
              w_currDimNext   = w_stepVal;
              w_dirNext       = w_stepDir;
              w_cycleDoneNext = w_stepDone;
              w_nextState     = ST_UPD;
            end else begin
              w_dwellCntNext = r_dwellCnt + 1'b1;
            end
          end
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; en=0 freezes all of them, including a pending cycle_done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_currDim   <= '0;
      r_dir       <= 1'b1;
      r_dwellCnt  <= '0;
      r_cfgReq    <= 1'b0;
      r_cycleDone <= 1'b0;
    end else if (en) begin
      r_state     <= w_nextState;
      r_currDim   <= w_currDimNext;
      r_dir       <= w_dirNext;
      r_dwellCnt  <= w_dwellCntNext;
      r_cfgReq    <= (w_nextState == ST_UPD);
      r_cycleDone <= w_cycleDoneNext;
    end
  end

  assign curr_dim   = r_currDim;
  assign cfg_req    = r_cfgReq;
  assign dir        = r_dir;
  assign cycle_done = r_cycleDone;

endmodule

// File: tb/tb_dc_mcl_trm_sweep_manager.sv
// tb_dc_mcl_trm_sweep_manager
// Directed scenarios with fixed expected sequences, then randomized traffic
// compared every cycle against an integer reference model of the sweeper.
module tb_dc_mcl_trm_sweep_manager;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        sweepEn;
  logic [1:0]  mode;
  logic [7:0]  step;
  logic [3:0]  dwell;
  logic        userIntValid;
  logic        confReady;
  logic [11:0] maxDim;
  logic [11:0] minDim;
  logic [11:0] currDim;
  logic        cfgReq;
  logic        dir;
  logic        cycleDone;

  int checks = 0;
  int errors = 0;

  int mPhase;
  int mCurr;
  int mDir;
  int mDwell;
  int mReq;
  int mDone;

  int t1Seq[7]   = '{14, 18, 20, 16, 12, 10, 14};
  int sawUpSeq[5] = '{3, 6, 7, 0, 3};
  int sawDnSeq[4] = '{4, 1, 0, 7};

  dc_mcl_trm_sweep_manager #(
    .SCR_SIZE_WIDTH(12),
    .STEP_WIDTH(8),
    .DWELL_WIDTH(4)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .en(en),
    .sweep_en(sweepEn),
    .mode(mode),
    .step(step),
    .dwell(dwell),
    .user_int_valid(userIntValid),
    .conf_ready(confReady),
    .max_dim(maxDim),
    .min_dim(minDim),
    .curr_dim(currDim),
    .cfg_req(cfgReq),
    .dir(dir),
    .cycle_done(cycleDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int clampDim(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic modelReset();
    mPhase = PH_IDLE;
    mCurr  = 0;
    mDir   = 1;
    mDwell = 0;
    mReq   = 0;
    mDone  = 0;
  endtask

  task automatic modelStep();
    int s;
    int lo;
    int hi;
    s  = (step == 8'd0) ? 1 : int'(step);
    lo = int'(minDim);
    hi = int'(maxDim);
    if (lo > hi) begin
      mCurr = lo;
      return;
    end
    case (mode)
      2'b00: begin
        if (mDir == 1) begin
          if (mCurr >= hi) begin
            mDir  = 0;
            mCurr = clampDim(mCurr - s, lo, hi);
          end else begin
            mCurr = clampDim(mCurr + s, lo, hi);
          end
        end else begin
          if (mCurr <= lo) begin
            mDir  = 1;
            mCurr = clampDim(mCurr + s, lo, hi);
            mDone = 1;
          end else begin
            mCurr = clampDim(mCurr - s, lo, hi);
          end
        end
      end
      2'b01: begin
        mDir = 1;
        if (mCurr >= hi) begin
          mCurr = lo;
          mDone = 1;
        end else begin
          mCurr = clampDim(mCurr + s, lo, hi);
        end
      end
      2'b10: begin
        mDir = 0;
        if (mCurr <= lo) begin
          mCurr = hi;
          mDone = 1;
        end else begin
          mCurr = clampDim(mCurr - s, lo, hi);
        end
      end
      default: begin
      end
    endcase
  endtask

  task automatic modelClock(input logic e, input logic se, input logic uiv, input logic cr);
    int startDim;
    int startDir;
    if (!e) return;
    startDim = (mode == 2'b10) ? int'(maxDim) : int'(minDim);
    startDir = (mode == 2'b10) ? 0 : 1;
    mDone = 0;
    if (!se) begin
      mPhase = PH_IDLE;
      mCurr  = startDim;
      mDir   = startDir;
      mDwell = 0;
    end else if (mPhase == PH_IDLE) begin
      mCurr  = startDim;
      mDir   = startDir;
      mDwell = 0;
      if (uiv) mPhase = PH_REQ;
    end else if (mPhase == PH_REQ) begin
      if (cr) mPhase = PH_WAIT;
    end else begin
      if (uiv && !cr) begin
        if (mDwell == int'(dwell)) begin
          mDwell = 0;
          modelStep();
          mPhase = PH_REQ;
        end else begin
          mDwell = (mDwell + 1) % 16;
        end
      end
    end
    mReq = (mPhase == PH_REQ) ? 1 : 0;
  endtask

  task automatic applyStimulus(input logic e, input logic se, input logic uiv, input logic cr);
    en           = e;
    sweepEn      = se;
    userIntValid = uiv;
    confReady    = cr;
    @(posedge clk);
    modelClock(e, se, uiv, cr);
    #1;
    checkOutput("curr_dim", int'(currDim), mCurr);
    checkOutput("cfg_req", int'(cfgReq), mReq);
    checkOutput("dir", int'(dir), mDir);
    checkOutput("cycle_done", int'(cycleDone), mDone);
  endtask

  task automatic setConfig(input int m, input int lo, input int hi, input int st, input int dw);
    mode   = 2'(m);
    minDim = 12'(lo);
    maxDim = 12'(hi);
    step   = 8'(st);
    dwell  = 4'(dw);
  endtask

  task automatic enterSweep(input string tag, input int expStart);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput({tag, "_start"}, int'(currDim), expStart);
    checkOutput({tag, "_req"}, int'(cfgReq), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic doStep(input string tag, input int expCurr, input int expDone);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput({tag, "_curr"}, int'(currDim), expCurr);
    checkOutput({tag, "_done"}, int'(cycleDone), expDone);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst = 1'b0;
    en = 1'b0;
    sweepEn = 1'b0;
    userIntValid = 1'b0;
    confReady = 1'b0;
    setConfig(0, 10, 20, 4, 0);
    modelReset();
    #12;
    checkOutput("rst_curr", int'(currDim), 0);
    checkOutput("rst_req", int'(cfgReq), 0);
    checkOutput("rst_dir", int'(dir), 1);
    checkOutput("rst_done", int'(cycleDone), 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    $display("[TB] triangle 10..20 step 4");
    setConfig(0, 10, 20, 4, 0);
    enterSweep("tri", 10);
    for (int i = 0; i < 7; i++) begin
      doStep("tri", t1Seq[i], (i == 6) ? 1 : 0);
    end

    $display("[TB] saw-up / saw-down 0..7 step 3");
    setConfig(1, 0, 7, 3, 0);
    enterSweep("sawup", 0);
    for (int i = 0; i < 5; i++) begin
      doStep("sawup", sawUpSeq[i], (i == 3) ? 1 : 0);
    end
    setConfig(2, 0, 7, 3, 0);
    enterSweep("sawdn", 7);
    checkOutput("sawdn_dir", int'(dir), 0);
    for (int i = 0; i < 4; i++) begin
      doStep("sawdn", sawDnSeq[i], (i == 3) ? 1 : 0);
    end

    $display("[TB] dwell 2, ignored frames");
    setConfig(0, 0, 30, 1, 2);
    enterSweep("dwell", 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("dwell_ignored", int'(currDim), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("dwell_f1", int'(currDim), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("dwell_f2", int'(currDim), 0);
    checkOutput("dwell_f2_req", int'(cfgReq), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("dwell_f3", int'(currDim), 1);
    checkOutput("dwell_f3_req", int'(cfgReq), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

    $display("[TB] sweep_en drop in WAIT");
    setConfig(0, 10, 20, 4, 0);
    enterSweep("drop", 10);
    doStep("drop", 14, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_curr", int'(currDim), 10);
    checkOutput("drop_req", int'(cfgReq), 0);
    checkOutput("drop_dir", int'(dir), 1);

    $display("[TB] en low during UPD");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("frz_curr", int'(currDim), 10);
      checkOutput("frz_req", int'(cfgReq), 1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("frz_wait_req", int'(cfgReq), 0);
    doStep("frz", 14, 0);

    $display("[TB] step 0, max lowered, reset in UPD");
    setConfig(0, 0, 30, 0, 0);
    enterSweep("step0", 0);
    doStep("step0", 1, 0);
    doStep("step0", 2, 0);
    setConfig(0, 0, 30, 4, 0);
    enterSweep("maxlow", 0);
    doStep("maxlow", 4, 0);
    doStep("maxlow", 8, 0);
    doStep("maxlow", 12, 0);
    maxDim = 12'd5;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("maxlow_clamp", int'(currDim), 5);
    checkOutput("maxlow_req", int'(cfgReq), 1);
    #2;
    nrst = 1'b0;
    #2;
    modelReset();
    checkOutput("midrst_curr", int'(currDim), 0);
    checkOutput("midrst_req", int'(cfgReq), 0);
    checkOutput("midrst_dir", int'(dir), 1);
    checkOutput("midrst_done", int'(cycleDone), 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    $display("[TB] randomized traffic");
    setConfig(0, 3, 25, 2, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mode   = 2'($urandom_range(0, 3));
        minDim = 12'($urandom_range(0, 20));
        maxDim = 12'($urandom_range(0, 40));
        step   = 8'($urandom_range(0, 9));
        dwell  = 4'($urandom_range(0, 3));
      end
      applyStimulus(($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
